// File: rtl/dll_tx_arbiter.sv
// Transmit-path arbiter: replay, DLLP and new-TLP sources share one registered
// 256-bit output toward PIPE; multi-beat packets hold a lock until their last beat.
module dll_tx_arbiter #(
  parameter int unsigned TLP_STARVE_MAX = 4
) (
  input  logic         sclk,
  input  logic         srst_n,
  input  logic [1:0]   dlcm_state_i,
  input  logic         rpl_valid_i,
  input  logic [255:0] rpl_data_i,
  input  logic         rpl_last_i,
  output logic         rpl_ready_o,
  input  logic         dllp_valid_i,
  input  logic [255:0] dllp_data_i,
  output logic         dllp_ready_o,
  input  logic         tlp_valid_i,
  input  logic [255:0] tlp_data_i,
  input  logic         tlp_last_i,
  output logic         tlp_ready_o,
  input  logic         pipe_ready_i,
  output logic         dll2pipe_valid_o,
  output logic [255:0] dll2pipe_data_o,
  output logic [1:0]   owner_o
);

  // Handshake: a beat moves when valid && ready are high in the same cycle;
  // producers hold valid/data until then, and ready never depends on a later edge.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_RPL = 2'd1,
    LOCK_TLP = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(TLP_STARVE_MAX);

  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  logic [255:0]   data_q, data_d;
  logic [3:0]     starve_cnt_q, starve_cnt_d;

  logic active, flush, out_free;
  logic grant_rpl, grant_dllp, grant_tlp;
  logic acc_rpl, acc_dllp, acc_tlp;

  assign active   = (dlcm_state_i == 2'd3);
  // Link down, or leaving Active mid-packet, drops whatever is in flight.
  assign flush    = (dlcm_state_i == 2'd0) || ((state_q != IDLE) && !active);
  assign out_free = !valid_q || pipe_ready_i;

  always_comb begin
    grant_rpl  = 1'b0;
    grant_dllp = 1'b0;
    grant_tlp  = 1'b0;
    owner_o    = 2'd0;
    if (srst_n && !flush && out_free) begin
      unique case (state_q)
        IDLE: begin
          if (active && rpl_valid_i)                                  grant_rpl  = 1'b1;
          else if (active && tlp_valid_i && starve_cnt_q == STARVE_MAX) grant_tlp  = 1'b1;
          else if (dlcm_state_i != 2'd0 && dllp_valid_i)              grant_dllp = 1'b1;
          else if (active && tlp_valid_i)                             grant_tlp  = 1'b1;
        end
        LOCK_RPL: grant_rpl = 1'b1;
        LOCK_TLP: grant_tlp = 1'b1;
        default: ;
      endcase
    end
    if (srst_n) begin
      unique case (state_q)
        LOCK_RPL: owner_o = 2'd1;
        LOCK_TLP: owner_o = 2'd3;
        default:  owner_o = grant_rpl ? 2'd1 : grant_tlp ? 2'd3 : grant_dllp ? 2'd2 : 2'd0;
      endcase
    end
  end

  assign rpl_ready_o  = grant_rpl;
  assign dllp_ready_o = grant_dllp;
  assign tlp_ready_o  = grant_tlp;

  assign acc_rpl  = grant_rpl  && rpl_valid_i;
  assign acc_dllp = grant_dllp && dllp_valid_i;
  assign acc_tlp  = grant_tlp  && tlp_valid_i;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    data_d       = data_q;
    starve_cnt_d = starve_cnt_q;
    if (flush) begin
      state_d      = IDLE;
      valid_d      = 1'b0;
      starve_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc_rpl && !rpl_last_i)      state_d = LOCK_RPL;
          else if (acc_tlp && !tlp_last_i) state_d = LOCK_TLP;
        end
        LOCK_RPL: if (acc_rpl && rpl_last_i) state_d = IDLE;
        LOCK_TLP: if (acc_tlp && tlp_last_i) state_d = IDLE;
        default:  state_d = IDLE;
      endcase

      if (acc_rpl || acc_dllp || acc_tlp) begin
        valid_d = 1'b1;
        data_d  = acc_rpl ? rpl_data_i : acc_tlp ? tlp_data_i : dllp_data_i;
      end else if (pipe_ready_i) begin
        valid_d = 1'b0;
      end

      if (acc_tlp && tlp_last_i)
        starve_cnt_d = 4'd0;
      else if (acc_dllp && tlp_valid_i && active && starve_cnt_q != STARVE_MAX)
        starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      data_q       <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign dll2pipe_valid_o = valid_q;
  assign dll2pipe_data_o  = data_q;

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed bench for dll_tx_arbiter: hand-computed expectations checked with
// immediate assertions after each cycle.
module tb_dll_tx_arbiter;

  logic         sclk = 1'b0;
  logic         srst_n;
  logic [1:0]   dlcm_state_i;
  logic         rpl_valid_i, rpl_last_i, rpl_ready_o;
  logic [255:0] rpl_data_i;
  logic         dllp_valid_i, dllp_ready_o;
  logic [255:0] dllp_data_i;
  logic         tlp_valid_i, tlp_last_i, tlp_ready_o;
  logic [255:0] tlp_data_i;
  logic         pipe_ready_i;
  logic         dll2pipe_valid_o;
  logic [255:0] dll2pipe_data_o;
  logic [1:0]   owner_o;

  int n_pass = 0;
  int n_total = 0;

  dll_tx_arbiter #(.TLP_STARVE_MAX(4)) dut (
    .sclk(sclk), .srst_n(srst_n), .dlcm_state_i(dlcm_state_i),
    .rpl_valid_i(rpl_valid_i), .rpl_data_i(rpl_data_i), .rpl_last_i(rpl_last_i),
    .rpl_ready_o(rpl_ready_o),
    .dllp_valid_i(dllp_valid_i), .dllp_data_i(dllp_data_i), .dllp_ready_o(dllp_ready_o),
    .tlp_valid_i(tlp_valid_i), .tlp_data_i(tlp_data_i), .tlp_last_i(tlp_last_i),
    .tlp_ready_o(tlp_ready_o),
    .pipe_ready_i(pipe_ready_i),
    .dll2pipe_valid_o(dll2pipe_valid_o), .dll2pipe_data_o(dll2pipe_data_o),
    .owner_o(owner_o)
  );

  always #5 sclk = ~sclk;

  function automatic logic [255:0] mk(input logic [31:0] k);
    return {8{k}};
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [255:0] exp);
    chk({tag, "_valid"}, {255'd0, dll2pipe_valid_o}, 256'd1);
    chk({tag, "_data"}, dll2pipe_data_o, exp);
  endtask

  initial begin
    srst_n = 1'b0; dlcm_state_i = 2'd3; pipe_ready_i = 1'b1;
    rpl_valid_i = 0; rpl_last_i = 0; rpl_data_i = '0;
    dllp_valid_i = 0; dllp_data_i = '0;
    tlp_valid_i = 1; tlp_last_i = 0; tlp_data_i = mk(32'hA000_0000);

    // Reset: everything quiet even with a valid source
    tick(); settle();
    chk("rst_valid", {255'd0, dll2pipe_valid_o}, 256'd0);
    chk("rst_data", dll2pipe_data_o, 256'd0);
    chk("rst_owner", {254'd0, owner_o}, 256'd0);
    chk("rst_tlp_ready", {255'd0, tlp_ready_o}, 256'd0);
    srst_n = 1'b1; settle();

    // Three-beat TLP, pipe always ready
    chk("t1_ready0", {255'd0, tlp_ready_o}, 256'd1);
    chk("t1_owner0", {254'd0, owner_o}, 256'd3);
    tick(); chk_out("t1_out0", mk(32'hA000_0000));
    chk("t1_owner_lock", {254'd0, owner_o}, 256'd3);
    tlp_data_i = mk(32'hA000_0001); settle();
    chk("t1_ready1", {255'd0, tlp_ready_o}, 256'd1);
    tick(); chk_out("t1_out1", mk(32'hA000_0001));
    tlp_data_i = mk(32'hA000_0002); tlp_last_i = 1; settle();
    chk("t1_ready2", {255'd0, tlp_ready_o}, 256'd1);
    tick(); chk_out("t1_out2", mk(32'hA000_0002));
    tlp_valid_i = 0; tlp_last_i = 0; settle();
    chk("t1_owner_idle", {254'd0, owner_o}, 256'd0);
    tick();
    chk("t1_drain", {255'd0, dll2pipe_valid_o}, 256'd0);

    // Four-beat TLP with a DLLP arriving during beat 2
    tlp_valid_i = 1; tlp_data_i = mk(32'hB000_0000); settle();
    tick(); chk_out("t2_out0", mk(32'hB000_0000));
    tlp_data_i = mk(32'hB000_0001);
    dllp_valid_i = 1; dllp_data_i = mk(32'hDD00_0001); settle();
    chk("t2_dllp_blocked", {255'd0, dllp_ready_o}, 256'd0);
    chk("t2_tlp_ready", {255'd0, tlp_ready_o}, 256'd1);
    tick(); chk_out("t2_out1", mk(32'hB000_0001));
    tlp_data_i = mk(32'hB000_0002); settle();
    tick(); chk_out("t2_out2", mk(32'hB000_0002));
    tlp_data_i = mk(32'hB000_0003); tlp_last_i = 1; settle();
    chk("t2_dllp_blocked3", {255'd0, dllp_ready_o}, 256'd0);
    tick(); chk_out("t2_out3", mk(32'hB000_0003));
    tlp_valid_i = 0; tlp_last_i = 0; settle();
    chk("t2_dllp_ready", {255'd0, dllp_ready_o}, 256'd1);
    chk("t2_dllp_owner", {254'd0, owner_o}, 256'd2);
    tick(); chk_out("t2_out_dllp", mk(32'hDD00_0001));
    dllp_valid_i = 0; settle();
    tick();

    // Replay wins over TLP and holds its lock to the last beat
    rpl_valid_i = 1; rpl_data_i = mk(32'hC000_0000);
    tlp_valid_i = 1; tlp_last_i = 1; tlp_data_i = mk(32'hE000_0000); settle();
    chk("t3_rpl_ready0", {255'd0, rpl_ready_o}, 256'd1);
    chk("t3_tlp_ready0", {255'd0, tlp_ready_o}, 256'd0);
    chk("t3_owner", {254'd0, owner_o}, 256'd1);
    tick(); chk_out("t3_out0", mk(32'hC000_0000));
    rpl_data_i = mk(32'hC000_0001); rpl_last_i = 1; settle();
    chk("t3_tlp_ready1", {255'd0, tlp_ready_o}, 256'd0);
    tick(); chk_out("t3_out1", mk(32'hC000_0001));
    rpl_valid_i = 0; rpl_last_i = 0; settle();
    chk("t3_tlp_ready2", {255'd0, tlp_ready_o}, 256'd1);
    tick(); chk_out("t3_out_tlp", mk(32'hE000_0000));
    tlp_valid_i = 0; tlp_last_i = 0; settle();
    tick();

    // DLLP stream starving a waiting TLP: four DLLPs, then the TLP
    dllp_valid_i = 1; tlp_valid_i = 1; tlp_last_i = 0; tlp_data_i = mk(32'hF000_0000);
    for (int i = 0; i < 4; i++) begin
      dllp_data_i = mk(32'hD100_0000 + 32'(i)); settle();
      chk("t4_dllp_ready", {255'd0, dllp_ready_o}, 256'd1);
      chk("t4_tlp_wait", {255'd0, tlp_ready_o}, 256'd0);
      tick(); chk_out("t4_dllp_out", mk(32'hD100_0000 + 32'(i)));
    end
    chk("t4_starve_full", {252'd0, dut.starve_cnt_q}, 256'd4);
    settle();
    chk("t4_tlp_promoted", {255'd0, tlp_ready_o}, 256'd1);
    chk("t4_dllp_held", {255'd0, dllp_ready_o}, 256'd0);
    tick(); chk_out("t4_tlp_out0", mk(32'hF000_0000));
    tlp_data_i = mk(32'hF000_0001); tlp_last_i = 1; settle();
    chk("t4_dllp_locked_out", {255'd0, dllp_ready_o}, 256'd0);
    tick(); chk_out("t4_tlp_out1", mk(32'hF000_0001));
    chk("t4_starve_clr", {252'd0, dut.starve_cnt_q}, 256'd0);
    tlp_valid_i = 0; tlp_last_i = 0; dllp_valid_i = 0; settle();
    tick();

    // DL_Init1: only DLLP eligible
    dlcm_state_i = 2'd1; tlp_valid_i = 1; tlp_data_i = mk(32'h1111_0000);
    dllp_valid_i = 1; dllp_data_i = mk(32'hD200_0000); settle();
    chk("t5_dllp_ready", {255'd0, dllp_ready_o}, 256'd1);
    chk("t5_tlp_ready", {255'd0, tlp_ready_o}, 256'd0);
    tick(); chk_out("t5_out", mk(32'hD200_0000));
    dllp_valid_i = 0; settle();
    chk("t5_tlp_still0", {255'd0, tlp_ready_o}, 256'd0);
    tick();
    chk("t5_drain", {255'd0, dll2pipe_valid_o}, 256'd0);
    tlp_valid_i = 0; dlcm_state_i = 2'd3; settle();

    // Backpressure mid-TLP
    tlp_valid_i = 1; tlp_data_i = mk(32'h5000_0000); settle();
    tick(); chk_out("t6_out0", mk(32'h5000_0000));
    pipe_ready_i = 0; tlp_data_i = mk(32'h5000_0001); tlp_last_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6_stall_ready", {255'd0, tlp_ready_o}, 256'd0);
      tick(); chk_out("t6_stall_hold", mk(32'h5000_0000));
    end
    pipe_ready_i = 1; settle();
    chk("t6_resume_ready", {255'd0, tlp_ready_o}, 256'd1);
    tick(); chk_out("t6_out1", mk(32'h5000_0001));
    tlp_valid_i = 0; tlp_last_i = 0; settle();
    tick();

    // Link drop mid-TLP flushes the packet
    tlp_valid_i = 1; tlp_data_i = mk(32'h6000_0000); settle();
    tick(); chk_out("t7_out0", mk(32'h6000_0000));
    dlcm_state_i = 2'd0; tlp_data_i = mk(32'h6000_0001);
    dllp_valid_i = 1; dllp_data_i = mk(32'hD300_0000); settle();
    chk("t7_tlp_ready", {255'd0, tlp_ready_o}, 256'd0);
    chk("t7_dllp_ready", {255'd0, dllp_ready_o}, 256'd0);
    tick();
    chk("t7_flush_valid", {255'd0, dll2pipe_valid_o}, 256'd0);
    chk("t7_flush_owner", {254'd0, owner_o}, 256'd0);
    dlcm_state_i = 2'd3; tlp_valid_i = 0; settle();
    chk("t7_dllp_after", {255'd0, dllp_ready_o}, 256'd1);

    // Asynchronous reset mid-cycle
    tick(); chk_out("t8_out", mk(32'hD300_0000));
    #2 srst_n = 1'b0;
    #1;
    chk("t8_rst_valid", {255'd0, dll2pipe_valid_o}, 256'd0);
    chk("t8_rst_data", dll2pipe_data_o, 256'd0);
    chk("t8_rst_owner", {254'd0, owner_o}, 256'd0);
    chk("t8_rst_dllp_ready", {255'd0, dllp_ready_o}, 256'd0);
    dllp_valid_i = 0;
    tick(); srst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dll_tx_arbiter.md
Name: dll_tx_arbiter

Overview:
Shares the single 256-bit DLL-to-PIPE transmit path between three sources: the retry-buffer replay stream, the DLLP generator (single-beat ACK/NAK/UpdateFC/InitFC), and new TLPs from the transaction layer. Multi-beat TLPs are never interleaved. Source selection is gated by the DLCM state. The output stage is registered, with valid/ready toward the PIPE transmit side.

Parameters:
TLP_STARVE_MAX, 4, consecutive DLLP grants with a TLP waiting before the TLP is promoted above DLLP (range 1..15).

Ports:
sclk  in  1  clock
srst_n  in  1  asynchronous active-low reset
dlcm_state_i  in  2  0=DL_Inactive, 1=DL_Init1, 2=DL_Init2, 3=DL_Active
rpl_valid_i  in  1  replay beat valid
rpl_data_i  in  256  replay beat
rpl_last_i  in  1  last beat of replayed TLP
rpl_ready_o  out  1  replay beat accepted
dllp_valid_i  in  1  DLLP beat valid (always single beat)
dllp_data_i  in  256  DLLP beat
dllp_ready_o  out  1  DLLP accepted (drives generator arb_ready)
tlp_valid_i  in  1  new TLP beat valid
tlp_data_i  in  256  new TLP beat
tlp_last_i  in  1  last beat of new TLP
tlp_ready_o  out  1  new TLP beat accepted
pipe_ready_i  in  1  PIPE TX accepts the output beat
dll2pipe_valid_o  out  1  output beat valid
dll2pipe_data_o  out  256  output beat
owner_o  out  2  current lock owner: 0=none, 1=replay, 2=DLLP, 3=TLP

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE, dll2pipe_valid_o=0, dll2pipe_data_o=0, starve_cnt=0, owner_o=0. All ready outputs are 0 during reset.
- out_free = !dll2pipe_valid_o || pipe_ready_i. A source beat is accepted when its valid and ready are both high.
- Accepted beat appears on dll2pipe_data_o with valid=1 at the next edge (latency 1).
- Output holds data and valid stable while pipe_ready_i=0.
- Eligibility: replay and TLP only when dlcm_state_i==3. DLLP when dlcm_state_i!=0.
- FSM states: IDLE, LOCK_RPL, LOCK_TLP.
- IDLE grant is combinational, same cycle, when out_free. Priority order:
  - replay first;
  - then TLP, if starve_cnt==TLP_STARVE_MAX and tlp_valid_i;
  - then DLLP;
  - then TLP.
  - Only the granted source sees ready=1.
- IDLE transitions on an accepted beat:
  - replay or TLP beat with last=0 -> LOCK_RPL or LOCK_TLP;
  - last=1 beat, or DLLP beat -> stay in IDLE (no bubble between packets).
- LOCK_x: only source x gets ready (=out_free). No other source is granted until x's last beat is accepted, then the FSM returns to IDLE. A pending replay does not preempt LOCK_TLP.
- owner_o: 1 or 3 while locked. In IDLE it reflects the source granted this cycle, or 0 if none.
- starve_cnt (4 bit):
  - +1 on each accepted DLLP while tlp_valid_i=1 and dlcm_state_i==3; saturates at TLP_STARVE_MAX;
  - cleared when a TLP beat with tlp_last_i=1 is accepted.
- dlcm_state_i==0 in any state forces, at the next edge: FSM=IDLE, dll2pipe_valid_o=0, starve_cnt=0. All readys are 0 in that same cycle; the partial packet is dropped.
- dlcm_state_i leaving 3 while in LOCK_TLP/LOCK_RPL (new value 1 or 2): same flush as above; DLLPs are then eligible again from IDLE.
- Sources must hold valid and data until accepted. The arbiter never drops an accepted beat, except on the flush above.

Test Plan:
- Active, tlp 3 beats (D0,D1,D2 last), pipe_ready=1 -> dll2pipe shows D0,D1,D2 on cycles 1..3 after start; tlp_ready high 3 cycles; owner_o=3.
- Active, dllp_valid raised during beat 2 of a 4-beat TLP -> DLLP appears on output only after TLP beat 4, with zero bubble.
- Active, replay and TLP both valid in IDLE -> replay granted first; TLP granted only after rpl_last accepted.
- Active, continuous DLLP stream plus TLP waiting, TLP_STARVE_MAX=4 -> 4 DLLPs go out, then the full TLP; starve_cnt returns to 0.
- dlcm_state=1, tlp_valid=1 and dllp_valid=1 -> only DLLP accepted; tlp_ready stays 0.
- pipe_ready=0 for 3 cycles mid-TLP -> output data stable and tlp_ready=0. Separately, dlcm_state->0 mid-TLP -> valid_o=0 at the next edge, FSM IDLE; async srst_n low -> all outputs 0 immediately.
